bcd_seq_conv: RTL and testbench

- Sequential binary-to-BCD converter controller using the shift-and-add-3 (double-dabble) algorithm.
- Replaces wide combinational lookup decoding for inputs wider than 4 bits.
- Sequences one per-digit adjust datapath over DATA_W cycles, with a start/busy/done handshake.
- Feeds the display/readout path: a 7-segment driver or digit scanner consumes bcd_o.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bcd_seq_conv.sv | 125 ++++++++++++
 tb/tb_bcd_seq_conv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } bcd_state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Smallest digit count d with 10^d >= 2^width, i.e. ceil(width*log10(2)).
    function automatic int unsigned bcd_digits(input int unsigned width);
        longint unsigned pow10;
        longint unsigned limit;
        int unsigned     d;
        pow10 = 1;
        limit = longint'(1) << width;
        d     = 0;
        while (pow10 < limit) begin
            pow10 = pow10 * 10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Define BCD_SIGNED_EN for two's-complement input with a separate sign_o output.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned DIGITS = bcd_digits(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
`ifdef BCD_SIGNED_EN
    ,
    output logic                  sign_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned ACC_W = 4 * DIGITS;

    bcd_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_adj;
    logic [ACC_W-1:0]  bcd_q, bcd_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

`ifdef BCD_SIGNED_EN
    logic sign_q, sign_d;

    // The most negative value negates to itself, which read unsigned is 2^(DATA_W-1).
    assign mag    = bin_i[DATA_W-1] ? -bin_i : bin_i;
    assign sign_o = sign_q;
`else
    assign mag    = bin_i;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
`ifdef BCD_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sr_d    = mag;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                    busy_d  = 1'b1;
                    state_d = CONVERT;
`ifdef BCD_SIGNED_EN
                    sign_d  = bin_i[DATA_W-1];
`endif
                end
            end
            CONVERT: begin
                {acc_d, sr_d} = {acc_adj[ACC_W-2:0], sr_q, 1'b0};
                cnt_d         = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
`ifdef BCD_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
`ifdef BCD_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed self-checking bench for bcd_seq_conv (DATA_W=8); honours BCD_SIGNED_EN.
module tb_bcd_seq_conv;

    localparam int unsigned DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  bin_i;
    logic        busy_o;
    logic        done_o;
    logic [11:0] bcd_o;
`ifdef BCD_SIGNED_EN
    logic        sign_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_seq_conv #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o)
`ifdef BCD_SIGNED_EN
        ,
        .sign_o  (sign_o)
`endif
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        sign;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m;
        m = int'(v);
`ifdef BCD_SIGNED_EN
        if (v[7]) m = 256 - int'(v);
`endif
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Issues a one-cycle start; lat counts rising edges after the accepting edge until done_o.
    task automatic convert(input logic [7:0] v, output logic [11:0] res, output int lat);
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = v;
        @(negedge clk);
        start_i = 1'b0;
        lat     = 0;
        while (!done_o && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        res = bcd_o;
    endtask

    vec_t        vecs[8];
    logic [11:0] res;
    int          lat;
    int          cnt;
    int          dones;

    initial begin
`ifdef BCD_SIGNED_EN
        vecs[0] = '{8'h00, 12'h000, 1'b0};
        vecs[1] = '{8'h80, 12'h128, 1'b1};
        vecs[2] = '{8'hFF, 12'h001, 1'b1};
        vecs[3] = '{8'h7F, 12'h127, 1'b0};
        vecs[4] = '{8'd99, 12'h099, 1'b0};
        vecs[5] = '{8'd10, 12'h010, 1'b0};
        vecs[6] = '{8'h9C, 12'h100, 1'b1};
        vecs[7] = '{8'd1,  12'h001, 1'b0};
`else
        vecs[0] = '{8'd0,   12'h000, 1'b0};
        vecs[1] = '{8'd255, 12'h255, 1'b0};
        vecs[2] = '{8'd99,  12'h099, 1'b0};
        vecs[3] = '{8'd10,  12'h010, 1'b0};
        vecs[4] = '{8'd1,   12'h001, 1'b0};
        vecs[5] = '{8'd128, 12'h128, 1'b0};
        vecs[6] = '{8'd200, 12'h200, 1'b0};
        vecs[7] = '{8'd9,   12'h009, 1'b0};
`endif

        rst_n   = 1'b0;
        start_i = 1'b0;
        bin_i   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_bcd",  32'(bcd_o),  32'd0);
`ifdef BCD_SIGNED_EN
        check("reset_sign", 32'(sign_o), 32'd0);
`endif
        rst_n = 1'b1;

        // Busy profile of a zero conversion: high through CONVERT and DONE, low with done.
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 8'd0;
        cnt     = 0;
        lat     = 0;
        @(negedge clk);
        start_i = 1'b0;
        while (!done_o && lat < 30) begin
            if (busy_o) cnt++;
            @(negedge clk);
            lat++;
        end
        check("zero_latency", 32'(lat), 32'd9);
        check("zero_busy_cycles", 32'(cnt), 32'd9);
        check("zero_busy_at_done", 32'(busy_o), 32'd0);
        check("zero_bcd", 32'(bcd_o), 32'h000);
        @(negedge clk);
        check("done_one_cycle", 32'(done_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].bin, res, lat);
            check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
`ifdef BCD_SIGNED_EN
            check($sformatf("vec%0d_sign", i), 32'(sign_o), 32'(vecs[i].sign));
`endif
        end

        for (int v = 0; v < 256; v++) begin
            convert(8'(v), res, lat);
            check($sformatf("sweep_%0d", v), 32'(res), 32'(ref_bcd(8'(v))));
        end

        // Previous result is 255's; it must hold while a new conversion runs.
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 8'd10;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_during_convert", 32'(bcd_o), 32'(ref_bcd(8'd255)));
        check("busy_mid_convert", 32'(busy_o), 32'd1);
        lat = 0;
        while (!done_o && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("hold_then_result", 32'(bcd_o), 32'(ref_bcd(8'd10)));

        // A start pulse mid-conversion with new data is ignored.
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 8'd200;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        bin_i   = 8'd7;
        @(negedge clk);
        start_i = 1'b0;
        lat     = 0;
        while (!done_o && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("ignored_start_bcd", 32'(bcd_o), 32'(ref_bcd(8'd200)));
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("ignored_start_no_second_done", 32'(dones), 32'd0);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 8'd123;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_bcd",  32'(bcd_o),  32'd0);
`ifdef BCD_SIGNED_EN
        check("abort_sign", 32'(sign_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        convert(8'd77, res, lat);
        check("after_abort_bcd", 32'(res), 32'h077);
        check("after_abort_latency", 32'(lat), 32'd9);

        // start_i held high: one result every DATA_W+2 cycles, each with data seen at its accept.
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 8'd1;
        for (int k = 1; k <= 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!done_o && cnt < 30);
            check($sformatf("b2b%0d_interval", k), 32'(cnt), 32'd10);
            check($sformatf("b2b%0d_bcd", k), 32'(bcd_o), 32'(ref_bcd(8'(k))));
            if (k < 3) bin_i = 8'(k + 1);
            else       start_i = 1'b0;
        end
        repeat (15) @(negedge clk);
        check("b2b_stopped", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
